reg_access_ctrl: RTL and testbench

//   Command-driven initiator for the 16x4 register file (the responder).

---
 rtl/miyamii_pkg.sv | 27 ++
 rtl/reg_access_ctrl_if.sv | 31 +++
 rtl/reg_acc_alu.sv | 48 ++++
 rtl/reg_access_ctrl.sv | 177 +++++++++++++++++
 tb/tb_reg_access_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/miyamii_pkg.sv
// rtl/miyamii_pkg.sv - shared constants, opcodes and FSM states for reg_access_ctrl
// Purpose: common definitions imported by the interface, the ALU and the top.
// Ports: none (package).
package miyamii_pkg;

   localparam int NIB_W   = 4;                  // nibble width; arithmetic assumes 4
   localparam int NREG    = 16;                 // registers in the file
   localparam int ADDR_W  = $clog2(NREG);       // single-register address width
   localparam int PAIR_AW = $clog2(NREG / 2);   // pair address width

   localparam logic [2:0] OP_RD4  = 3'd0;
   localparam logic [2:0] OP_WR4  = 3'd1;
   localparam logic [2:0] OP_RD8  = 3'd2;
   localparam logic [2:0] OP_WR8  = 3'd3;
   localparam logic [2:0] OP_INC4 = 3'd4;
   localparam logic [2:0] OP_INC8 = 3'd5;
   localparam logic [2:0] OP_XCH4 = 3'd6;
   localparam logic [2:0] OP_DEC4 = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2,
      S_RESP = 2'd3
   } state_t;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// rtl/reg_access_ctrl_if.sv - command/response handshake bundle for reg_access_ctrl
// Purpose: groups the command channel and the response channel.
// Signals: cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data (command),
//          rsp_valid/rsp_ready/rsp_data/rsp_carry/rsp_zero (response).
// Modports: slave = controller side, master = requester side.
interface reg_access_ctrl_if;
   import miyamii_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [2:0]           cmd_op;
   logic [ADDR_W-1:0]    cmd_addr;
   logic [2*NIB_W-1:0]   cmd_data;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [2*NIB_W-1:0]   rsp_data;
   logic                 rsp_carry;
   logic                 rsp_zero;

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
   );

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
   );

endinterface

// File: rtl/reg_acc_alu.sv
// rtl/reg_acc_alu.sv - combinational increment/decrement with carry and zero flags
// Purpose: 4-bit inc/dec (mod 16) or 8-bit inc (mod 256) for read-modify-write ops.
// Ports: a_i    operand (4-bit ops use the low nibble)
//        wide_i 1 = 8-bit increment, 0 = 4-bit operation
//        dec_i  1 = 4-bit decrement (ignored when wide_i)
//        y_o    result, 4-bit results zero-extended
//        carry_o wrap on increment / borrow on decrement
//        zero_o y_o == 0
module reg_acc_alu
   import miyamii_pkg::*;
(
   input  logic [2*NIB_W-1:0] a_i,
   input  logic               wide_i,
   input  logic               dec_i,
   output logic [2*NIB_W-1:0] y_o,
   output logic               carry_o,
   output logic               zero_o
);

   localparam logic [NIB_W:0]   N_ONE = {{NIB_W{1'b0}}, 1'b1};
   localparam logic [2*NIB_W:0] W_ONE = {{(2*NIB_W){1'b0}}, 1'b1};

   logic [NIB_W:0]   n_sum;
   logic [2*NIB_W:0] w_sum;

   always_comb begin
      n_sum   = '0;
      w_sum   = '0;
      y_o     = '0;
      carry_o = 1'b0;
      // The extra top bit holds the wrap: 0_1111+1 and 0_0000-1 both set it.
      if (dec_i) begin
         n_sum = {1'b0, a_i[NIB_W-1:0]} - N_ONE;
      end else begin
         n_sum = {1'b0, a_i[NIB_W-1:0]} + N_ONE;
      end
      w_sum = {1'b0, a_i} + W_ONE;
      if (wide_i) begin
         y_o     = w_sum[2*NIB_W-1:0];
         carry_o = w_sum[2*NIB_W];
      end else begin
         y_o     = {{NIB_W{1'b0}}, n_sum[NIB_W-1:0]};
         carry_o = n_sum[NIB_W];
      end
      zero_o = (y_o == '0);
   end

endmodule

// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - command-driven initiator for the 16x4 register file
// Purpose: accepts one command at a time, sequences 4/8-bit reads, writes and
//          read-modify-writes on the register file, returns a response.
// Ports: clk, rst_n (async active-low)
//        bus           command/response channels (reg_access_ctrl_if.slave)
//        rf_reg_*      single-register port of the file (addr, wdata, we, rdata)
//        rf_pair_*     pair port of the file (addr, wdata, we, rdata); [7:4] is the even reg
//        perf_wr_cnt   saturating write-cycle counter, present only with REGACC_PERF_EN
module reg_access_ctrl
   import miyamii_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
`ifdef REGACC_PERF_EN
   output logic [15:0]         perf_wr_cnt,
`endif
   reg_access_ctrl_if.slave    bus,
   output logic [ADDR_W-1:0]   rf_reg_addr,
   output logic [NIB_W-1:0]    rf_reg_wdata,
   output logic                rf_reg_we,
   input  logic [NIB_W-1:0]    rf_reg_rdata,
   output logic [PAIR_AW-1:0]  rf_pair_addr,
   output logic [2*NIB_W-1:0]  rf_pair_wdata,
   output logic                rf_pair_we,
   input  logic [2*NIB_W-1:0]  rf_pair_rdata
);

   state_t               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [2*NIB_W-1:0]   data_q, data_d;
   logic [2*NIB_W-1:0]   result_q, result_d;
   logic                 carry_q, carry_d;
   logic                 zero_q, zero_d;
   logic [2*NIB_W-1:0]   wval_q, wval_d;     // value written back in WB

   logic [2*NIB_W-1:0]   alu_a;
   logic [2*NIB_W-1:0]   alu_y;
   logic                 alu_carry;
   logic                 alu_zero;

   assign alu_a = (op_q == OP_INC8) ? rf_pair_rdata : {{NIB_W{1'b0}}, rf_reg_rdata};

   reg_acc_alu u_alu (
      .a_i     (alu_a),
      .wide_i  (op_q == OP_INC8),
      .dec_i   (op_q == OP_DEC4),
      .y_o     (alu_y),
      .carry_o (alu_carry),
      .zero_o  (alu_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= OP_RD4;
         addr_q   <= '0;
         data_q   <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         wval_q   <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         wval_q   <= wval_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      data_d     = data_q;
      result_d   = result_q;
      carry_d    = carry_q;
      zero_d     = zero_q;
      wval_d     = wval_q;
      rf_reg_we  = 1'b0;
      rf_pair_we = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               addr_d  = bus.cmd_addr;
               data_d  = bus.cmd_data;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            carry_d = 1'b0;
            case (op_q)
               OP_RD4: begin
                  result_d = {{NIB_W{1'b0}}, rf_reg_rdata};
                  zero_d   = (rf_reg_rdata == '0);
                  state_d  = S_RESP;
               end
               OP_WR4: begin
                  rf_reg_we = 1'b1;
                  result_d  = {{NIB_W{1'b0}}, data_q[NIB_W-1:0]};
                  zero_d    = (data_q[NIB_W-1:0] == '0);
                  state_d   = S_RESP;
               end
               OP_RD8: begin
                  result_d = rf_pair_rdata;
                  zero_d   = (rf_pair_rdata == '0);
                  state_d  = S_RESP;
               end
               OP_WR8: begin
                  rf_pair_we = 1'b1;
                  result_d   = data_q;
                  zero_d     = (data_q == '0);
                  state_d    = S_RESP;
               end
               OP_XCH4: begin
                  // Return the old value; the new one is written in WB.
                  result_d = {{NIB_W{1'b0}}, rf_reg_rdata};
                  zero_d   = (rf_reg_rdata == '0);
                  wval_d   = {{NIB_W{1'b0}}, data_q[NIB_W-1:0]};
                  state_d  = S_WB;
               end
               default: begin
                  // INC4 / INC8 / DEC4 return the new value.
                  result_d = alu_y;
                  carry_d  = alu_carry;
                  zero_d   = alu_zero;
                  wval_d   = alu_y;
                  state_d  = S_WB;
               end
            endcase
         end
         S_WB: begin
            rf_pair_we = (op_q == OP_INC8);
            rf_reg_we  = (op_q != OP_INC8);
            state_d    = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_data  = result_q;
   assign bus.rsp_carry = carry_q;
   assign bus.rsp_zero  = zero_q;

   assign rf_reg_addr   = addr_q;
   assign rf_pair_addr  = addr_q[ADDR_W-1:1];
   assign rf_reg_wdata  = (state_q == S_WB) ? wval_q[NIB_W-1:0] : data_q[NIB_W-1:0];
   assign rf_pair_wdata = (state_q == S_WB) ? wval_q : data_q;

`ifdef REGACC_PERF_EN
   logic [15:0] perf_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cnt_q <= '0;
      end else if ((rf_reg_we || rf_pair_we) && (perf_cnt_q != 16'hFFFF)) begin
         perf_cnt_q <= perf_cnt_q + 16'd1;
      end
   end

   assign perf_wr_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - self-checking bench for reg_access_ctrl
module tb_reg_access_ctrl;
   import miyamii_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] rf_reg_addr;
   logic [3:0] rf_reg_wdata;
   logic       rf_reg_we;
   logic [3:0] rf_reg_rdata;
   logic [2:0] rf_pair_addr;
   logic [7:0] rf_pair_wdata;
   logic       rf_pair_we;
   logic [7:0] rf_pair_rdata;
`ifdef REGACC_PERF_EN
   logic [15:0] perf_wr_cnt;
`endif

   reg_access_ctrl_if bus ();

   reg_access_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef REGACC_PERF_EN
      .perf_wr_cnt   (perf_wr_cnt),
`endif
      .bus           (bus.slave),
      .rf_reg_addr   (rf_reg_addr),
      .rf_reg_wdata  (rf_reg_wdata),
      .rf_reg_we     (rf_reg_we),
      .rf_reg_rdata  (rf_reg_rdata),
      .rf_pair_addr  (rf_pair_addr),
      .rf_pair_wdata (rf_pair_wdata),
      .rf_pair_we    (rf_pair_we),
      .rf_pair_rdata (rf_pair_rdata)
   );

   always #5 clk = ~clk;

   // Register file responder
   logic [3:0] rf_mem [16] = '{default: 4'h0};
   assign rf_reg_rdata  = rf_mem[rf_reg_addr];
   assign rf_pair_rdata = {rf_mem[{rf_pair_addr, 1'b0}], rf_mem[{rf_pair_addr, 1'b1}]};

   always @(posedge clk) begin
      if (rf_reg_we) rf_mem[rf_reg_addr] <= rf_reg_wdata;
      if (rf_pair_we) begin
         rf_mem[{rf_pair_addr, 1'b0}] <= rf_pair_wdata[7:4];
         rf_mem[{rf_pair_addr, 1'b1}] <= rf_pair_wdata[3:0];
      end
   end

   // Write-enable monitor
   int reg_we_cnt = 0;
   int pair_we_cnt = 0;
   int both_cnt = 0;
   always @(posedge clk) begin
      if (rf_reg_we) reg_we_cnt++;
      if (rf_pair_we) pair_we_cnt++;
      if (rf_reg_we && rf_pair_we) both_cnt++;
   end

   int total = 0;
   int bad = 0;
   int model_mem [16] = '{default: 0};
   int perf_exp = 0;

   // Reference model: applies one command to model_mem and returns expectations.
   task automatic model_cmd(input logic [2:0] op, input logic [3:0] addr, input logic [7:0] data,
                            output logic [7:0] ed, output logic ec, output logic ez,
                            output int el, output int erwe, output int epwe);
      int a, p, old, nv, d, dv;
      a = addr; p = (a / 2) * 2; dv = data;
      d = 0; ec = 1'b0; erwe = 0; epwe = 0;
      case (op)
         OP_RD4: d = model_mem[a];
         OP_WR4: begin d = dv % 16; model_mem[a] = d; erwe = 1; end
         OP_RD8: d = model_mem[p] * 16 + model_mem[p + 1];
         OP_WR8: begin d = dv; model_mem[p] = dv / 16; model_mem[p + 1] = dv % 16; epwe = 1; end
         OP_INC4: begin
            old = model_mem[a]; nv = (old + 1) % 16; ec = (old == 15);
            d = nv; model_mem[a] = nv; erwe = 1;
         end
         OP_INC8: begin
            old = model_mem[p] * 16 + model_mem[p + 1]; nv = (old + 1) % 256; ec = (old == 255);
            d = nv; model_mem[p] = nv / 16; model_mem[p + 1] = nv % 16; epwe = 1;
         end
         OP_XCH4: begin d = model_mem[a]; model_mem[a] = dv % 16; erwe = 1; end
         default: begin
            old = model_mem[a]; nv = (old + 15) % 16; ec = (old == 0);
            d = nv; model_mem[a] = nv; erwe = 1;
         end
      endcase
      ed = 8'(d);
      ez = (d == 0);
      el = (op >= 3'd4) ? 3 : 2;
      perf_exp += erwe + epwe;
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [3:0] addr, input logic [7:0] data,
                          input int hold, input bit noisy, output logic [7:0] got);
      logic [7:0] ed;
      logic ec, ez;
      int el, erwe, epwe, lat, guard, memerr;
      model_cmd(op, addr, data, ed, ec, ez, el, erwe, epwe);
      @(negedge clk);
      reg_we_cnt = 0; pair_we_cnt = 0; both_cnt = 0;
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_data = data;
      guard = 0;
      while (!bus.cmd_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      total++;
      if (bus.cmd_ready !== 1'b1) begin
         bad++; $display("FAIL accept_wait: cmd_ready=%b required 1", bus.cmd_ready);
      end
      @(negedge clk);
      bus.cmd_valid = noisy ? 1'($urandom) : 1'b0;
      bus.cmd_op = 3'($urandom); bus.cmd_addr = 4'($urandom); bus.cmd_data = 8'($urandom);
      lat = 1;
      while (!bus.rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
         if (noisy) bus.cmd_valid = 1'($urandom);
      end
      bus.cmd_valid = 1'b0;
      total++;
      if (lat !== el) begin bad++; $display("FAIL latency op=%0d: got %0d required %0d", op, lat, el); end
      total++;
      if (bus.rsp_data !== ed) begin bad++; $display("FAIL rsp_data op=%0d: got %h required %h", op, bus.rsp_data, ed); end
      total++;
      if (bus.rsp_carry !== ec) begin bad++; $display("FAIL rsp_carry op=%0d: got %b required %b", op, bus.rsp_carry, ec); end
      total++;
      if (bus.rsp_zero !== ez) begin bad++; $display("FAIL rsp_zero op=%0d: got %b required %b", op, bus.rsp_zero, ez); end
      got = bus.rsp_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         total++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ed || bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_stable cyc=%0d: valid=%b data=%h ready=%b required 1 %h 0",
                     i, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, ed);
         end
         bus.cmd_valid = noisy; bus.cmd_op = 3'($urandom); bus.cmd_addr = 4'($urandom);
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         bad++; $display("FAIL release: rsp_valid=%b cmd_ready=%b required 0 1", bus.rsp_valid, bus.cmd_ready);
      end
      memerr = 0;
      for (int i = 0; i < 16; i++) if (int'(rf_mem[i]) != model_mem[i]) memerr++;
      total++;
      if (memerr != 0) begin bad++; $display("FAIL mem op=%0d: %0d registers differ, required 0", op, memerr); end
      total++;
      if (reg_we_cnt != erwe || pair_we_cnt != epwe || both_cnt != 0) begin
         bad++;
         $display("FAIL we_pulses op=%0d: reg=%0d pair=%0d both=%0d required %0d %0d 0",
                  op, reg_we_cnt, pair_we_cnt, both_cnt, erwe, epwe);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b required 1", bus.cmd_ready); end
      total++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_zero} !== 11'h0) begin
         bad++; $display("FAIL reset_rsp: got %b%h%b%b required all 0", bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_zero);
      end
      total++;
      if ({rf_reg_addr, rf_reg_wdata, rf_reg_we, rf_pair_addr, rf_pair_wdata, rf_pair_we} !== 21'h0) begin
         bad++; $display("FAIL reset_rf: got %h %h %b %h %h %b required all 0",
                         rf_reg_addr, rf_reg_wdata, rf_reg_we, rf_pair_addr, rf_pair_wdata, rf_pair_we);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [7:0] got;
      run_cmd(OP_WR4, 4'd5, 8'h0A, 0, 1'b0, got);
      run_cmd(OP_RD4, 4'd5, 8'h00, 0, 1'b0, got);
      total++;
      if (got !== 8'h0A) begin bad++; $display("FAIL rd4_reg5: got %h required 0a", got); end
      run_cmd(OP_WR8, 4'd6, 8'h3C, 0, 1'b0, got);
      total++;
      if (rf_mem[6] !== 4'h3 || rf_mem[7] !== 4'hC) begin
         bad++; $display("FAIL wr8_split: reg6=%h reg7=%h required 3 c", rf_mem[6], rf_mem[7]);
      end
      run_cmd(OP_RD8, 4'd7, 8'h00, 0, 1'b0, got);
      total++;
      if (got !== 8'h3C) begin bad++; $display("FAIL rd8_odd_addr: got %h required 3c", got); end
      run_cmd(OP_WR4, 4'd8, 8'h0F, 0, 1'b0, got);
      run_cmd(OP_INC4, 4'd8, 8'h00, 0, 1'b0, got);
      total++;
      if (got !== 8'h00) begin bad++; $display("FAIL inc4_wrap: got %h required 00", got); end
      run_cmd(OP_DEC4, 4'd8, 8'h00, 0, 1'b0, got);
      total++;
      if (got !== 8'h0F) begin bad++; $display("FAIL dec4_borrow: got %h required 0f", got); end
      run_cmd(OP_WR8, 4'd4, 8'hFF, 0, 1'b0, got);
      run_cmd(OP_INC8, 4'd4, 8'h00, 0, 1'b0, got);
      run_cmd(OP_RD8, 4'd5, 8'h00, 0, 1'b0, got);
      total++;
      if (got !== 8'h00) begin bad++; $display("FAIL inc8_wrap_readback: got %h required 00", got); end
      run_cmd(OP_WR4, 4'd3, 8'h07, 0, 1'b0, got);
      run_cmd(OP_XCH4, 4'd3, 8'h02, 0, 1'b0, got);
      total++;
      if (got !== 8'h07 || rf_mem[3] !== 4'h2) begin
         bad++; $display("FAIL xch4: rsp=%h reg3=%h required 07 2", got, rf_mem[3]);
      end
   endtask

   task automatic test_hold();
      logic [7:0] got;
      run_cmd(OP_RD8, 4'd6, 8'($urandom), 5, 1'b1, got);
      run_cmd(OP_INC4, 4'd5, 8'($urandom), 5, 1'b1, got);
   endtask

   task automatic test_random();
      logic [7:0] got;
      for (int i = 0; i < 40; i++) begin
         run_cmd(3'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'($urandom), got);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] got;
      int guard;
      run_cmd(OP_WR4, 4'd9, 8'h0F, 0, 1'b0, got);
      @(negedge clk);
      reg_we_cnt = 0; pair_we_cnt = 0; both_cnt = 0;
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_INC4; bus.cmd_addr = 4'd9; bus.cmd_data = 8'h00;
      guard = 0;
      while (!bus.cmd_ready && guard < 20) begin @(negedge clk); guard++; end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         bad++; $display("FAIL midrst_now: cmd_ready=%b rsp_valid=%b required 1 0", bus.cmd_ready, bus.rsp_valid);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      perf_exp = 0;
      repeat (3) @(negedge clk);
      total++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         bad++; $display("FAIL midrst_after: cmd_ready=%b rsp_valid=%b required 1 0", bus.cmd_ready, bus.rsp_valid);
      end
      total++;
      if (reg_we_cnt != 0 || pair_we_cnt != 0) begin
         bad++; $display("FAIL midrst_we: reg=%0d pair=%0d required 0 0", reg_we_cnt, pair_we_cnt);
      end
      total++;
      if (rf_mem[9] !== 4'hF) begin bad++; $display("FAIL midrst_reg9: got %h required f", rf_mem[9]); end
      for (int i = 0; i < 6; i++) begin
         run_cmd(3'($urandom), 4'($urandom), 8'($urandom), 0, 1'b0, got);
      end
   endtask

`ifdef REGACC_PERF_EN
   task automatic test_perf();
      total++;
      if (int'(perf_wr_cnt) != perf_exp) begin
         bad++; $display("FAIL perf_wr_cnt: got %0d required %0d", perf_wr_cnt, perf_exp);
      end
   endtask
`endif

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_addr = 4'd0; bus.cmd_data = 8'd0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_directed();
      test_hold();
      test_random();
      test_reset_mid();
`ifdef REGACC_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
